// File: rtl/stoch_pkg.sv
// Shared types and constants for the stochastic multiplier: FSM states,
// product-mode encoding, and the 31-bit PRBS generator definition.
package stoch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MODE_UNIPOLAR = 1'b0;
  localparam logic MODE_BIPOLAR  = 1'b1;

  // Fibonacci LFSR for x^31 + x^28 + 1, shifted left with feedback into bit 0
  localparam int LFSR_W = 31;
  localparam int TAP_HI = 30;
  localparam int TAP_LO = 27;

  localparam logic [LFSR_W-1:0] DEF_SEED_A = 31'h0000_0001;
  localparam logic [LFSR_W-1:0] DEF_SEED_B = 31'h2A5C_3F1D;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

endpackage

// File: rtl/lfsr_sng.sv
// Stochastic number generator: LFSR, magnitude comparator against the
// operand, and the registered stream bit (pipeline stage 1).
module lfsr_sng
  import stoch_pkg::*;
#(
  parameter int                WIDTH = 4,
  parameter logic [LFSR_W-1:0] SEED  = DEF_SEED_A
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_prob,
  output logic             o_sn
);

  logic [LFSR_W-1:0] r_lfsr;
  logic              r_sn;
  logic [WIDTH-1:0]  w_top;
  logic              w_sn;

  assign w_top = r_lfsr[LFSR_W-1 -: WIDTH];
  assign w_sn  = (w_top < i_prob);

  // Reload takes priority so each conversion replays the same sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
      r_sn   <= 1'b0;
    end else if (i_load) begin
      r_lfsr <= SEED;
      r_sn   <= 1'b0;
    end else if (i_en) begin
      r_lfsr <= lfsr_next(r_lfsr);
      r_sn   <= w_sn;
    end
  end

  assign o_sn = r_sn;

endmodule

// File: rtl/stochastic_mult_engine.sv
// Stochastic multiplier: two LFSR-driven bit streams combined by AND
// (unipolar) or XNOR (bipolar), with the ones counted over 2^LOG2_LEN bits.
module stochastic_mult_engine
  import stoch_pkg::*;
#(
  parameter int                WIDTH    = 4,
  parameter int                LOG2_LEN = 8,
  parameter logic [LFSR_W-1:0] SEED_A   = DEF_SEED_A,
  parameter logic [LFSR_W-1:0] SEED_B   = DEF_SEED_B
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                mode,
  input  logic [WIDTH-1:0]    prob_a,
  input  logic [WIDTH-1:0]    prob_b,
  output logic                busy,
  output logic                done,
  output logic [LOG2_LEN:0]   result
);

  state_t              r_state;
  logic [LOG2_LEN-1:0] r_run_cnt;
  logic                r_drain_cnt;
  logic [WIDTH-1:0]    r_prob_a;
  logic [WIDTH-1:0]    r_prob_b;
  logic                r_mode;
  logic                r_v1;
  logic                r_v2;
  logic                r_prod;
  logic [LOG2_LEN:0]   r_count;
  logic [LOG2_LEN:0]   r_result;

  logic                w_accept;
  logic                w_abort;
  logic                w_run;
  logic                w_sn_a;
  logic                w_sn_b;
  logic                w_prod;
  logic                w_inc;
  logic                w_finish;
  logic [LOG2_LEN:0]   w_count_next;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_abort  = abort && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
  assign w_run    = (r_state == ST_RUN);
  assign w_finish = (r_state == ST_DRAIN) && r_drain_cnt && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_run_cnt   <= '0;
      r_drain_cnt <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_RUN;
            r_run_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (&r_run_cnt) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= 1'b0;
          end else begin
            r_run_cnt <= r_run_cnt + LOG2_LEN'(1);
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (r_drain_cnt) begin
            r_state <= ST_DONE;
          end else begin
            r_drain_cnt <= 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Operands are frozen at acceptance so later input changes cannot leak in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prob_a <= '0;
      r_prob_b <= '0;
      r_mode   <= MODE_UNIPOLAR;
    end else if (w_accept) begin
      r_prob_a <= prob_a;
      r_prob_b <= prob_b;
      r_mode   <= mode;
    end
  end

  lfsr_sng #(.WIDTH(WIDTH), .SEED(SEED_A)) u_sng_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_en   (w_run),
    .i_prob (r_prob_a),
    .o_sn   (w_sn_a)
  );

  lfsr_sng #(.WIDTH(WIDTH), .SEED(SEED_B)) u_sng_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_en   (w_run),
    .i_prob (r_prob_b),
    .o_sn   (w_sn_b)
  );

  assign w_prod = (r_mode == MODE_BIPOLAR) ? ~(w_sn_a ^ w_sn_b) : (w_sn_a & w_sn_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_prod <= 1'b0;
    end else begin
      if (w_accept || w_abort) begin
        r_v1 <= 1'b0;
        r_v2 <= 1'b0;
      end else begin
        r_v1 <= w_run;
        r_v2 <= r_v1;
      end
      r_prod <= w_prod;
    end
  end

  assign w_inc        = r_prod & r_v2;
  assign w_count_next = r_count + (LOG2_LEN+1)'(w_inc);

  // The final product bit lands on the same edge that enters DONE, so the
  // result captures the incremented value rather than the stored count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_count <= '0;
      end else if (w_inc) begin
        r_count <= w_count_next;
      end
      if (w_finish) begin
        r_result <= w_count_next;
      end
    end
  end

  assign busy   = (r_state != ST_IDLE);
  assign done   = (r_state == ST_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_stochastic_mult_engine.sv
// Scoreboard bench for stochastic_mult_engine: stimulus pushes expected
// result ranges and done timing, a negedge monitor pops on every done pulse.
module tb_stochastic_mult_engine;

  localparam int WIDTH    = 4;
  localparam int LOG2_LEN = 8;
  localparam int LEN      = 1 << LOG2_LEN;
  localparam int DONE_LAT = LEN + 2;
  // A well-mixed seed for A keeps the 0.5 x 0.5 unipolar product near 64;
  // a single-bit seed would leave stream A almost all ones for 256 cycles
  localparam logic [30:0] TB_SEED_A = 31'h6B8E_2D47;
  localparam logic [30:0] TB_SEED_B = 31'h2A5C_3F1D;

  logic                clk    = 1'b0;
  logic                rst_n  = 1'b1;
  logic                start  = 1'b0;
  logic                abort  = 1'b0;
  logic                mode   = 1'b0;
  logic [WIDTH-1:0]    probA  = '0;
  logic [WIDTH-1:0]    probB  = '0;
  logic                busy;
  logic                done;
  logic [LOG2_LEN:0]   result;

  stochastic_mult_engine #(
    .WIDTH    (WIDTH),
    .LOG2_LEN (LOG2_LEN),
    .SEED_A   (TB_SEED_A),
    .SEED_B   (TB_SEED_B)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .mode   (mode),
    .prob_a (probA),
    .prob_b (probB),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int tag;
    int lo;
    int hi;
    int doneCyc;
    bit sameAsPrev;
  } exp_t;

  exp_t sbQueue[$];
  int   vecCount = 0;
  int   errCount = 0;
  int   lastResult = -1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sbQueue.size() == 0) begin
        vecCount++;
        errCount++;
        $display("[TB] FAIL unexpectedDone: got done with result %0d, expected no done", result);
      end else begin
        exp_t e;
        e = sbQueue.pop_front();
        vecCount++;
        if ($isunknown(result) || int'(result) < e.lo || int'(result) > e.hi) begin
          errCount++;
          $display("[TB] FAIL conv%0d result: got %0d, expected %0d..%0d", e.tag, result, e.lo, e.hi);
        end
        vecCount++;
        if (cyc != e.doneCyc) begin
          errCount++;
          $display("[TB] FAIL conv%0d doneTiming: got cycle %0d, expected cycle %0d", e.tag, cyc, e.doneCyc);
        end
        if (e.sameAsPrev) begin
          vecCount++;
          if (int'(result) != lastResult) begin
            errCount++;
            $display("[TB] FAIL conv%0d repeat: got %0d, expected %0d", e.tag, result, lastResult);
          end
        end
        lastResult = int'(result);
      end
    end
  end

  task automatic applyStimulus(input logic m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input bit withAbort, input int tag, input int lo, input int hi,
                               input bit same);
    exp_t e;
    @(negedge clk);
    mode  = m;
    probA = a;
    probB = b;
    start = 1'b1;
    abort = withAbort;
    e.tag        = tag;
    e.lo         = lo;
    e.hi         = hi;
    e.doneCyc    = cyc + 1 + DONE_LAT;
    e.sameAsPrev = same;
    sbQueue.push_back(e);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sbQueue.size() != 0 && n < 2 * LEN) begin
      @(negedge clk);
      n++;
    end
    if (sbQueue.size() != 0) begin
      vecCount++;
      errCount++;
      $display("[TB] FAIL doneTimeout: got no done within %0d cycles, expected %0d pending", n, sbQueue.size());
      sbQueue.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", busy, 1'b0);
    checkOutput("resetDone", done, 1'b0);
    checkOutput("resetResult", result, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero operand in AND mode gives an all-zero product
    applyStimulus(1'b0, 4'd0, 4'd15, 1'b0, 1, 0, 0, 1'b0);
    waitDrain();

    // Both streams all zero, XNOR makes every product bit one
    applyStimulus(1'b1, 4'd0, 4'd0, 1'b0, 2, LEN, LEN, 1'b0);
    waitDrain();

    // Asynchronous reset mid-RUN discards the conversion and clears result
    @(negedge clk);
    mode = 1'b1; probA = 4'd0; probB = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    checkOutput("busyBeforeReset", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midResetBusy", busy, 1'b0);
    checkOutput("midResetDone", done, 1'b0);
    checkOutput("midResetResult", result, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(1'b1, 4'd0, 4'd0, 1'b0, 3, LEN, LEN, 1'b0);
    waitDrain();

    // Half times half, then again to confirm deterministic reseeding
    applyStimulus(1'b0, 4'd8, 4'd8, 1'b0, 4, 48, 80, 1'b0);
    waitDrain();
    applyStimulus(1'b0, 4'd8, 4'd8, 1'b0, 5, 48, 80, 1'b1);
    waitDrain();

    // Zero the result first so the next conversion's 256 is a visible change
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 6, 0, 0, 1'b0);
    waitDrain();

    // Start and operand changes while busy must not disturb the conversion
    applyStimulus(1'b1, 4'd0, 4'd0, 1'b0, 7, LEN, LEN, 1'b0);
    repeat (20) @(negedge clk);
    mode = 1'b0; probA = 4'd15; probB = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busyInRun", busy, 1'b1);
    waitDrain();

    // Abort at RUN cycle 100: back to IDLE, no done, result retained
    @(negedge clk);
    mode = 1'b0; probA = 4'd0; probB = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abortBusy", busy, 1'b0);
    repeat (LEN + 40) @(negedge clk);
    checkOutput("abortResult", result, LEN);

    // Start and abort together in IDLE: start wins
    applyStimulus(1'b0, 4'd0, 4'd15, 1'b1, 8, 0, 0, 1'b0);
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/stochastic_mult_engine.md
STOCHASTIC_MULT_ENGINE -- requirements
Module: stochastic_mult_engine

Interface
REQ-001 Parameter WIDTH, default 4, meaning bit width of each binary probability operand (2..8).
REQ-002 Parameter LOG2_LEN, default 8, meaning stream length is 2^LOG2_LEN bits (3..12).
REQ-003 Parameter SEED_A, default 31'h0000_0001, meaning LFSR A reload value (nonzero).
REQ-004 Parameter SEED_B, default 31'h2A5C_3F1D, meaning LFSR B reload value (nonzero, != SEED_A).
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  request a conversion; sampled only in IDLE.
REQ-008 abort  input  1  synchronous cancel of an in-flight conversion.
REQ-009 mode  input  1  0 = unipolar (AND), 1 = bipolar (XNOR).
REQ-010 prob_a  input  WIDTH  operand A probability, value/2^WIDTH.
REQ-011 prob_b  input  WIDTH  operand B probability, value/2^WIDTH.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when result updates.
REQ-014 result  output  LOG2_LEN+1  count of 1s in the product stream, range 0..2^LOG2_LEN.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-016 In IDLE with start=1 the block SHALL latch prob_a, prob_b, mode, reload LFSRs with SEED_A/SEED_B, clear the ones counter, and enter RUN.
REQ-017 start SHALL be ignored in RUN, DRAIN and DONE; no queueing.
REQ-018 Each LFSR SHALL be 31-bit Fibonacci, feedback x^31+x^28+1, shifting left once per cycle in RUN and holding otherwise.
REQ-019 Stage 1: SN bit = (top WIDTH bits of LFSR) < latched operand, registered; A and B use their own LFSR.
REQ-020 Stage 2: product bit = AND (mode 0) or XNOR (mode 1) of the two stage-1 bits, registered.
REQ-021 A valid flag SHALL follow the two-stage pipeline; the counter SHALL increment only when product bit=1 and valid=1.
REQ-022 RUN SHALL last exactly 2^LOG2_LEN cycles, then DRAIN exactly 2 cycles, then DONE 1 cycle, then IDLE.
REQ-023 Exactly 2^LOG2_LEN product bits SHALL be counted per conversion; the counter SHALL not wrap (LOG2_LEN+1 bits).
REQ-024 On entering DONE, result SHALL load the count and done SHALL be 1 for that cycle only; done rises 2^LOG2_LEN+2 edges after the accepting edge.
REQ-025 result SHALL hold its value until the next DONE.
REQ-026 abort=1 in RUN or DRAIN SHALL return to IDLE on the next edge, no done pulse, result unchanged; abort in IDLE/DONE has no effect.
REQ-027 abort and start together in IDLE: start SHALL win (abort ignored).
REQ-028 Operand changes while busy SHALL not affect the current conversion.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, busy 0, done 0, result 0, counter 0, valid flags 0, stage registers 0, LFSR A = SEED_A, LFSR B = SEED_B.
REQ-030 Reset asserted mid-conversion SHALL discard it with no done pulse; deassertion SHALL leave the block in IDLE.

Structure
REQ-031 Package stoch_pkg SHALL hold the state enum, mode encoding constants, LFSR width/tap constants and default seeds.
REQ-032 One sub-module lfsr_sng (LFSR + comparator + stage-1 register, with seed and WIDTH parameters) SHALL be instantiated twice.

Verification
REQ-033 Reset mid-RUN -> busy, done, result immediately 0; next start runs normally.
REQ-034 mode=0, prob_a=0, prob_b=15 (WIDTH=4, LEN=256) -> done after 258 edges, result=0.
REQ-035 mode=1, prob_a=0, prob_b=0 -> result=256 (both streams all-0, XNOR all-1).
REQ-036 mode=0, prob_a=8, prob_b=8 -> result within 64 +/- 16; identical result on repeat (deterministic reseed).
REQ-037 start pulsed during RUN and operands changed -> ignored; single done, result per original operands.
REQ-038 abort at RUN cycle 100 -> IDLE next cycle, no done, result retains prior value.
